// File: rtl/keypad_scanner_if.sv
// Keypad-facing signal bundle: row sense in, column drive and decoded key out.
// The scanner takes the slave side; the keypad/board model takes the master side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_pulse;

    modport master (
        output row,
        input  col,
        input  key_value,
        input  key_valid,
        input  key_pulse
    );

    modport slave (
        input  row,
        output col,
        output key_value,
        output key_valid,
        output key_pulse
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates a one-hot column drive, debounces press and release on scan ticks.
// Latency: key_valid/key_pulse appear one cycle after the DEBOUNCE_TICKS-th stable tick.
// Backpressure: none; key_pulse is a single-cycle strobe and key_valid is a level.
module keypad_scanner #(
    parameter int SCAN_DIV_BITS  = 17,
    parameter int DEBOUNCE_TICKS = 4
) (
    input logic             clk,
    input logic             reset_p,
    keypad_scanner_if.slave kp
);
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [2:0] DB_TICKS = 3'(DEBOUNCE_TICKS);
    localparam logic [SCAN_DIV_BITS-1:0] DIV_ONE = {{(SCAN_DIV_BITS-1){1'b0}}, 1'b1};

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [3:0]               r_row_m;
    logic [3:0]               r_row_s;
    logic [SCAN_DIV_BITS-1:0] r_div;
    logic [2:0]               r_cnt;
    logic [2:0]               w_cnt_nxt;
    logic [3:0]               r_row_lat;
    logic [3:0]               w_row_lat_nxt;
    logic [3:0]               r_col;
    logic [3:0]               w_col_nxt;
    logic [3:0]               r_key_value;
    logic [3:0]               w_key_value_nxt;
    logic                     r_key_valid;
    logic                     w_key_valid_nxt;
    logic                     r_key_pulse;
    logic                     w_key_pulse_nxt;
    logic                     w_tick;
    logic                     w_row_zero;
    logic                     w_row_onehot;
    logic [2:0]               w_cnt_inc;

    function automatic logic [1:0] f_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Row lines are asynchronous to clk, so only the twice-registered copy is used.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_row_m <= 4'b0000;
            r_row_s <= 4'b0000;
            r_div   <= '0;
        end else begin
            r_row_m <= kp.row;
            r_row_s <= r_row_m;
            r_div   <= r_div + DIV_ONE;
        end
    end

    assign w_tick       = &r_div;
    assign w_row_zero   = (r_row_s == 4'b0000);
    assign w_row_onehot = !w_row_zero && ((r_row_s & (r_row_s - 4'd1)) == 4'b0000);
    assign w_cnt_inc    = r_cnt + 3'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_row_lat_nxt   = r_row_lat;
        w_col_nxt       = r_col;
        w_key_value_nxt = r_key_value;
        w_key_valid_nxt = r_key_valid;
        w_key_pulse_nxt = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_row_zero) begin
                        w_col_nxt = {r_col[2:0], r_col[3]};
                    end else if (w_row_onehot) begin
                        w_row_lat_nxt = r_row_s;
                        w_cnt_nxt     = 3'd1;
                        w_state_nxt   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (w_row_zero) begin
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = SCAN;
                    end else if (!w_row_onehot) begin
                        w_cnt_nxt = 3'd0;
                    end else if (r_row_s == r_row_lat) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == DB_TICKS) begin
                            w_state_nxt     = PRESSED;
                            w_key_value_nxt = {f_idx(r_row_lat), f_idx(r_col)};
                            w_key_valid_nxt = 1'b1;
                            w_key_pulse_nxt = 1'b1;
                        end
                    end else begin
                        // A different single key took over mid-debounce: restart on it.
                        w_row_lat_nxt = r_row_s;
                        w_cnt_nxt     = 3'd1;
                    end
                end
                PRESSED: begin
                    if (w_row_zero) begin
                        w_cnt_nxt   = 3'd1;
                        w_state_nxt = RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_row_zero) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == DB_TICKS) begin
                            w_cnt_nxt       = 3'd0;
                            w_state_nxt     = SCAN;
                            w_key_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_state_nxt = PRESSED;
                    end
                end
                default: begin
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state     <= SCAN;
            r_cnt       <= 3'd0;
            r_row_lat   <= 4'b0000;
            r_col       <= 4'b0001;
            r_key_value <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_row_lat   <= w_row_lat_nxt;
            r_col       <= w_col_nxt;
            r_key_value <= w_key_value_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_pulse <= w_key_pulse_nxt;
        end
    end

    assign kp.col       = r_col;
    assign kp.key_value = r_key_value;
    assign kp.key_valid = r_key_valid;
    assign kp.key_pulse = r_key_pulse;
endmodule
